// File: rtl/interval_timer_pkg.sv
// interval_timer_pkg: shared state encoding, time width and default tick rate for the interval timer
package interval_timer_pkg;
  localparam int TIME_W = 5;
  localparam int DEFAULT_TICKS_PER_SEC = 50_000_000;
  typedef enum logic [1:0] {IDLE, LOAD, COUNT, EXPIRED} state_t;
endpackage

// File: rtl/interval_timer_if.sv
// interval_timer_if: control/status bundle of the interval timer
// master drives start_timer and value; slave (the timer) returns expired, busy, remaining, one_hz_enable
interface interval_timer_if;
  import interval_timer_pkg::*;
  logic start_timer;
  logic [TIME_W-1:0] value;
  logic expired;
  logic busy;
  logic [TIME_W-1:0] remaining;
  logic one_hz_enable;
  modport master (output start_timer, value, input expired, busy, remaining, one_hz_enable);
  modport slave (input start_timer, value, output expired, busy, remaining, one_hz_enable);
endinterface

// File: rtl/interval_timer_tick_prescaler.sv
// tick_prescaler: counts enabled cycles 0..TICKS-1 and flags the last one as tick
// ports: clock, reset (sync, active-high), clear (force count to 0), enable (count this cycle), tick (enable && count==TICKS-1)
module tick_prescaler #(
  parameter int TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(TICKS);
  localparam logic [W-1:0] LAST = W'(TICKS - 1);
  logic [W-1:0] count;
  assign tick = enable && count == LAST;
  always_ff @(posedge clock) begin
    if (reset || clear) count <= '0;
    else if (enable) count <= tick ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/interval_timer.sv
// interval_timer: loads a seconds value, counts it down on a one-second tick and pulses expired at the end
// ports: clock, reset (sync, active-high), bus (interval_timer_if.slave: start_timer/value in; expired/busy/remaining/one_hz_enable out)
module interval_timer
  import interval_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
  input logic clock,
  input logic reset,
  interval_timer_if.slave bus
);
  state_t state, state_nx;
  logic tick, expired_q, busy_q;
  logic [TIME_W-1:0] remaining;
  // A restart request clears the prescaler; outside COUNT it is held at zero.
  tick_prescaler #(.TICKS(TICKS_PER_SEC)) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clear (bus.start_timer || state != COUNT),
    .enable(state == COUNT),
    .tick  (tick)
  );
  // LOAD ignores start_timer; in COUNT/EXPIRED a restart beats tick and expiry.
  always_comb begin
    state_nx = state == IDLE ? (bus.start_timer ? LOAD : IDLE) :
               state == LOAD ? (bus.value == '0 ? EXPIRED : COUNT) :
               bus.start_timer ? LOAD :
               state == COUNT ? (tick && remaining == TIME_W'(1) ? EXPIRED : COUNT) : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      expired_q <= state_nx == EXPIRED;
      busy_q    <= state_nx == LOAD || state_nx == COUNT;
      if (state == LOAD) remaining <= bus.value;
      else if (state == COUNT && !bus.start_timer && tick) remaining <= remaining - 1'b1;
    end
  end
  assign bus.expired       = expired_q;
  assign bus.busy          = busy_q;
  assign bus.remaining     = remaining;
  assign bus.one_hz_enable = tick;
endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: scoreboard bench for interval_timer with a 4-cycle second
module tb_interval_timer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n = 0;
  int checks = 0;
  int errors = 0;
  int e0 = 0;
  bit oh_seen = 1'b0;
  int exp_q[$];
  interval_timer_if bus();
  interval_timer #(.TICKS_PER_SEC(4)) dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) n++;
  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (edge %0d)", tag, got, want, n);
    end
  endtask
  always @(negedge clock) begin
    if (bus.one_hz_enable === 1'b1) oh_seen = 1'b1;
    if (bus.expired === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_expired", n, -1);
      else check("expired_edge", n, exp_q.pop_front());
    end
  end
  task automatic start_run(input int v);
    @(negedge clock);
    bus.start_timer = 1'b1;
    bus.value = 5'(v);
    e0 = n + 1;
    exp_q.push_back(e0 + 1 + 4 * v);
    @(negedge clock);
    bus.start_timer = 1'b0;
  endtask
  task automatic wait_to(input int target);
    while (n < target) @(negedge clock);
  endtask
  task automatic drain();
    int lim = 0;
    while (exp_q.size() > 0 && lim < 300) begin
      @(negedge clock);
      lim++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(negedge clock);
    check("idle_busy", int'(bus.busy), 0);
  endtask
  initial begin
    bus.start_timer = 1'b0;
    bus.value = '0;
    repeat (2) @(negedge clock);
    bus.start_timer = 1'b1;
    @(negedge clock);
    check("rst_expired", int'(bus.expired), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_remaining", int'(bus.remaining), 0);
    check("rst_one_hz", int'(bus.one_hz_enable), 0);
    bus.start_timer = 1'b0;
    reset = 1'b0;
    start_run(6);
    check("v6_busy_load", int'(bus.busy), 1);
    for (int k = 0; k < 6; k++) begin
      wait_to(e0 + 1 + 4 * k);
      check("v6_remaining", int'(bus.remaining), 6 - k);
      if (k == 0) begin
        wait_to(e0 + 4);
        check("v6_one_hz", int'(bus.one_hz_enable), 1);
      end
    end
    drain();
    oh_seen = 1'b0;
    start_run(0);
    drain();
    check("v0_one_hz_seen", int'(oh_seen), 0);
    check("v0_remaining", int'(bus.remaining), 0);
    start_run(10);
    wait_to(e0 + 14);
    check("v10_remaining", int'(bus.remaining), 7);
    exp_q.delete();
    start_run(3);
    drain();
    start_run(2);
    wait_to(e0 + 9);
    check("v2_expired_now", int'(bus.expired), 1);
    bus.start_timer = 1'b1;
    exp_q.push_back(e0 + 10 + 1 + 8);
    @(negedge clock);
    bus.start_timer = 1'b0;
    check("v2_reload_busy", int'(bus.busy), 1);
    drain();
    start_run(15);
    wait_to(e0 + 20);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    check("abort_expired", int'(bus.expired), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_remaining", int'(bus.remaining), 0);
    check("abort_one_hz", int'(bus.one_hz_enable), 0);
    repeat (80) @(negedge clock);
    check("abort_stays_idle", int'(bus.busy), 0);
    start_run(31);
    wait_to(e0 + 1);
    check("v31_remaining_top", int'(bus.remaining), 31);
    wait_to(e0 + 1 + 4 * 30);
    check("v31_remaining_last", int'(bus.remaining), 1);
    drain();
    check("v31_remaining_end", int'(bus.remaining), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 Parameter TICKS_PER_SEC, default 50_000_000, clock cycles per one-second tick; SHALL be >= 2.
REQ-002 clock  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 start_timer  input  1  request to (re)start a countdown; level sampled each edge.
REQ-005 value  input  5  interval length in seconds, driven by the time-parameter block; valid one cycle after the interval select changes.
REQ-006 expired  output  1  registered, one-cycle pulse at countdown end.
REQ-007 busy  output  1  high while state is LOAD or COUNT.
REQ-008 remaining  output  5  seconds left, registered.
REQ-009 one_hz_enable  output  1  combinational tick, high in COUNT when prescaler == TICKS_PER_SEC-1.

Function
REQ-010 States SHALL be IDLE, LOAD, COUNT, EXPIRED; encoding in shared package.
REQ-011 IDLE: start_timer=1 -> LOAD; else stay.
REQ-012 LOAD lasts exactly one cycle: covers the one-cycle latency of value after the interval select changes; at the LOAD->next edge remaining <= value, prescaler <= 0.
REQ-013 LOAD with value != 0 -> COUNT; value == 0 -> EXPIRED (no COUNT cycles).
REQ-014 COUNT, no tick: prescaler increments by 1; remaining unchanged.
REQ-015 COUNT, tick: prescaler <= 0, remaining <= remaining-1; if remaining == 1 -> EXPIRED.
REQ-016 expired SHALL be high exactly during the single cycle the state is EXPIRED; EXPIRED -> IDLE unconditionally unless start_timer=1 (-> LOAD).
REQ-017 start_timer=1 in COUNT or EXPIRED SHALL restart: -> LOAD, prescaler <= 0; restart wins over a simultaneous tick or expiry.
REQ-018 start_timer=1 in LOAD SHALL be ignored (LOAD proceeds normally).
REQ-019 Total latency: start sampled at edge E0 -> expired high in the cycle after edge E(1+value*TICKS_PER_SEC); value 0 -> expired high after E1.
REQ-020 remaining SHALL never wrap below 0; prescaler width = clog2(TICKS_PER_SEC), never exceeds TICKS_PER_SEC-1.
REQ-021 In IDLE and EXPIRED prescaler holds 0; one_hz_enable low.

Reset
REQ-022 reset=1 at an edge SHALL force state IDLE, prescaler 0, remaining 0, expired 0; busy 0, one_hz_enable 0.
REQ-023 reset SHALL take priority over start_timer and any in-progress countdown; no expired pulse results from an aborted countdown.

Structure
REQ-024 Shared package SHALL hold the state enumeration, the 5-bit time width constant and the default TICKS_PER_SEC.
REQ-025 One sub-module, tick_prescaler (counter + clear + enable, tick output), SHALL generate one_hz_enable; the rest is a single FSM/datapath.

Verification (TICKS_PER_SEC=4)
REQ-026 value=6, start pulse at E0 -> busy high from E0, remaining 6,5,..,1 changing every 4 cycles, expired one cycle after E25, then IDLE.
REQ-027 value=0, start at E0 -> expired high one cycle after E1, one_hz_enable never high, remaining 0.
REQ-028 value=10, start, restart with value=3 when remaining=7 -> no expired for first run; expired 13 edges after restart sampled.
REQ-029 value=2, start held high at the EXPIRED cycle -> LOAD next, new countdown, expired pulses exactly once per run.
REQ-030 value=15, reset asserted mid-COUNT for 1 cycle -> all outputs 0 next cycle, no expired pulse, IDLE until next start.
REQ-031 value=31 (max) -> remaining counts 31..1 without wrap; expired after E125.
